// File: rtl/event_blinker_pkg.sv
// event_blinker_pkg: state encoding and default timing constants for event_blinker
package event_blinker_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } state_e;
   localparam int unsigned DEF_DIV       = 32'hFF;
   localparam int unsigned DEF_ON_TICKS  = 8;
   localparam int unsigned DEF_GAP_TICKS = 8;
endpackage

// File: rtl/event_blinker_tick_gen.sv
// tick_gen: clock-enable prescaler, one tick every DIV+1 cycles
// Ports: clk, rst (sync, active-high), restart (same effect as rst), tick (high when count==DIV)
module tick_gen import event_blinker_pkg::*; #(
   parameter int unsigned DIV = DEF_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   logic [15:0] cnt_q, cnt_d;
   assign tick = cnt_q == 16'(DIV);
   always_comb cnt_d = (restart || tick) ? 16'd0 : cnt_q + 16'd1;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 16'd0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/event_blinker.sv
// event_blinker: renders single-cycle events as timed ON pulses each followed by an OFF gap
// Ports: clk, rst (sync, active-high), evt (event strobe), clr_ovf (clear sticky overflow),
//        out_level (LED/buzzer drive), busy (not idle), pending (queued events), overflow (event dropped)
module event_blinker import event_blinker_pkg::*; #(
   parameter int unsigned DIV       = DEF_DIV,
   parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
   parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evt,
   input  logic              clr_ovf,
   output logic              out_level,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);
   state_e            state_q, state_d;
   logic [7:0]        tcnt_q, tcnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d, out_q, out_d, busy_q, busy_d;
   logic              tick, restart, deq, full, drop, last_on, last_gap;

   // every state change restarts the prescaler so each phase is a whole number of ticks
   assign restart = state_d != state_q;

   tick_gen #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign deq      = state_q == ST_IDLE && pend_q != '0;
   assign full     = pend_q == '1;
   assign drop     = evt && !deq && full;
   assign last_on  = tick && tcnt_q == 8'(ON_TICKS - 1);
   assign last_gap = tick && tcnt_q == 8'(GAP_TICKS - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         tcnt_q  <= 8'd0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         tcnt_q  <= tcnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   // GAP always runs to completion before a queued event can start a new pulse
   always_comb begin
      state_d = (state_q == ST_IDLE && deq)      ? ST_ON   :
                (state_q == ST_ON   && last_on)  ? ST_GAP  :
                (state_q == ST_GAP  && last_gap) ? ST_IDLE :
                (state_q inside {ST_IDLE, ST_ON, ST_GAP}) ? state_q : ST_IDLE;
      tcnt_d  = restart ? 8'd0 : tick ? tcnt_q + 8'd1 : tcnt_q;
   end

   always_comb begin
      out_d  = state_d == ST_ON;
      busy_d = state_d != ST_IDLE;
   end

   // simultaneous enqueue and dequeue leaves the count unchanged; a full queue drops the event
   always_comb begin
      pend_d = (evt && !deq && !full) ? pend_q + 1'b1 :
               (deq && !evt)          ? pend_q - 1'b1 : pend_q;
      ovf_d  = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
   end

   assign out_level = out_q;
   assign busy      = busy_q;
   assign pending   = pend_q;
   assign overflow  = ovf_q;
endmodule
